// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - fixed-latency 128-bit line backing store answering cache miss/writeback requests
module cache_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mem_req_addr,
    input  logic [127:0] mem_req_data,
    input  logic         mem_req_rw,
    input  logic         mem_req_valid,
    output logic [127:0] mem_data_data,
    output logic         mem_data_ready
);

    localparam int         DEPTH    = 1 << INDEX_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [3:0]            count;
    logic [INDEX_BITS-1:0] idx_q;
    logic [127:0]          wdata_q;
    logic                  rw_q;
    logic [127:0]          rdata_q;
    logic                  accept;
    logic                  finish;

    logic [127:0] store [0:DEPTH-1];

    // Address bits outside the line index only alias onto the same line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr[31:INDEX_BITS+4], mem_req_addr[3:0]};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx_q   <= mem_req_addr[INDEX_BITS+3:4];
                wdata_q <= mem_req_data;
                rw_q    <= mem_req_rw;
                count   <= CNT_LOAD;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (finish && !rw_q) begin
                rdata_q <= store[idx_q];
            end
        end
    end

    // Store is not reset; an aborted write never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (finish && rw_q) begin
            store[idx_q] <= wdata_q;
        end
    end

    assign mem_data_ready = finish;
    // Read data is visible during the ready cycle itself, then held in rdata_q.
    assign mem_data_data  = (finish && !rw_q) ? store[idx_q] : rdata_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder
module tb_cache_mem_responder;

    localparam int LAT = 4;
    localparam int IB  = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  mem_req_addr = '0;
    logic [127:0] mem_req_data = '0;
    logic         mem_req_rw = 1'b0;
    logic         mem_req_valid = 1'b0;
    logic [127:0] mem_data_data;
    logic         mem_data_ready;

    logic [31:0]  a1 = '0;
    logic [127:0] w1 = '0;
    logic         rw1 = 1'b0;
    logic         v1 = 1'b0;
    logic [127:0] dd1;
    logic         r1;

    cache_mem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clk(clk), .reset(reset),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
        .mem_data_data(mem_data_data), .mem_data_ready(mem_data_ready)
    );

    cache_mem_responder #(.LATENCY(1), .INDEX_BITS(IB)) dut_l1 (
        .clk(clk), .reset(reset),
        .mem_req_addr(a1), .mem_req_data(w1),
        .mem_req_rw(rw1), .mem_req_valid(v1),
        .mem_data_data(dd1), .mem_data_ready(r1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        bit           wr;
        logic [127:0] data;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] held_exp = '0;
    logic [127:0] model [int];
    int           written[$];

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every ready pulse pops one expectation; between pulses the output must hold.
    always @(negedge clk) begin
        exp_t         e;
        logic [127:0] exp_d;
        if (reset) begin
            held_exp = '0;
        end else if (mem_data_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready at cycle %0d", cyc);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ready_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                exp_d = e.wr ? held_exp : e.data;
                checks++;
                if (mem_data_data !== exp_d) begin
                    errors++;
                    $display("FAIL resp_data wr=%0b got=%h exp=%h", e.wr, mem_data_data, exp_d);
                end
                if (!e.wr) held_exp = e.data;
            end
        end else begin
            checks++;
            if (mem_data_data !== held_exp) begin
                errors++;
                $display("FAIL hold_data cycle %0d got=%h exp=%h", cyc, mem_data_data, held_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after DONE with valid still high.
    task automatic do_req(input logic [31:0] addr, input logic [127:0] data, input logic rw);
        exp_t e;
        int   idx;
        int   n;
        idx           = int'(addr[IB+3:4]);
        mem_req_addr  = addr;
        mem_req_data  = data;
        mem_req_rw    = rw;
        mem_req_valid = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc + LAT - 1;
        e.wr  = rw;
        if (rw) begin
            if (!model.exists(idx)) written.push_back(idx);
            model[idx] = data;
            e.data     = data;
        end else begin
            e.data = model[idx];
        end
        sb_q.push_back(e);
        @(negedge clk);
        mem_req_addr = $urandom;
        mem_req_data = rand128();
        mem_req_rw   = 1'($urandom_range(0, 1));
        #1;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout pending=%0d exp_cycle=%0d", sb_q.size(), sb_q[0].cyc);
            sb_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [127:0] line_a;
    logic [127:0] line_b;
    logic [31:0]  addr;
    int           idx;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {127'd0, mem_data_ready}, 128'd0);
        chk("reset_data", mem_data_data, 128'd0);
        chk("reset_ready_l1", {127'd0, r1}, 128'd0);
        chk("reset_data_l1", dd1, 128'd0);
        reset = 1'b0;

        line_a = {32'hDEADBEEF, 64'h0, 32'h0000_0001};
        do_req(32'h0000_0010, line_a, 1'b1);
        do_req(32'h0000_0010, 128'd0, 1'b0);

        line_b = rand128();
        do_req(32'h0000_1020, line_b, 1'b1);
        do_req(32'h0000_0020, 128'd0, 1'b0);
        mem_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 15);
                addr[IB+3:4] = idx[IB-1:0];
                do_req(addr, rand128(), 1'b1);
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                addr[IB+3:4] = idx[IB-1:0];
                do_req(addr, 128'd0, 1'b0);
            end
            if ($urandom_range(0, 2) == 0) begin
                mem_req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        mem_req_valid = 1'b0;
        @(negedge clk);

        line_a = rand128();
        do_req(32'h0000_0050, line_a, 1'b1);
        mem_req_valid = 1'b0;
        @(negedge clk);
        mem_req_addr  = 32'h0000_0050;
        mem_req_data  = rand128();
        mem_req_rw    = 1'b1;
        mem_req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_ready", {127'd0, mem_data_ready}, 128'd0);
        chk("abort_data", mem_data_data, 128'd0);
        mem_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_req(32'h0000_0050, 128'd0, 1'b0);
        mem_req_valid = 1'b0;
        @(negedge clk);

        line_b = rand128();
        a1  = 32'h0000_0030;
        w1  = line_b;
        rw1 = 1'b1;
        v1  = 1'b1;
        @(posedge clk);
        #1;
        chk("l1_ready_t1", {127'd0, r1}, 128'd1);
        @(posedge clk);
        #1;
        chk("l1_done_no_ready", {127'd0, r1}, 128'd0);
        @(negedge clk);
        w1  = 128'd0;
        rw1 = 1'b0;
        @(posedge clk);
        #1;
        chk("l1_no_duplicate", {127'd0, r1}, 128'd0);
        @(posedge clk);
        #1;
        chk("l1_read_ready", {127'd0, r1}, 128'd1);
        chk("l1_read_data", dd1, line_b);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("l1_ready_low", {127'd0, r1}, 128'd0);
        chk("l1_data_held", dd1, line_b);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
